sensor_ctrl: RTL and testbench

SENSOR_CTRL -- requirements
Module: sensor_ctrl

---
 rtl/sensor_ctrl_pkg.sv | 13 +
 rtl/sensor_buffer.sv | 24 ++
 rtl/sensor_ctrl.sv | 83 ++++++++
 tb/tb_sensor_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_ctrl_pkg.sv
// sensor_ctrl_pkg: shared FSM encoding, default buffer depth and status-address offset.
package sensor_ctrl_pkg;

    localparam int DEPTH_DEFAULT = 64;
    localparam int STATUS_OFFSET = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        FULL   = 2'd2
    } state_t;

endpackage

// File: rtl/sensor_buffer.sv
// sensor_buffer: DEPTH x 32 register file, one synchronous write port, one combinational read port.
module sensor_buffer
    import sensor_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge CLK)
        if (we) mem[waddr] <= wdata;

    // Reads see the old word during a same-index write.
    assign rdata = mem[raddr];

endmodule

// File: rtl/sensor_ctrl.sv
// sensor_ctrl: fills a DEPTH-word sample buffer from an external sensor, raises a sticky full interrupt.
// Define SENSOR_CTRL_OVERRUN_EN for a sticky overrun flag and a status word at address DEPTH.
module sensor_ctrl
    import sensor_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        sctrl_en,
    input  logic        sctrl_clear,
    input  logic [11:0] sctrl_addr,
    output logic [31:0] sctrl_out,
    output logic        sctrl_interrupt,
    output logic        sensor_en,
    input  logic        sensor_ready,
    input  logic [31:0] sensor_out
);

    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t      state, next_state;
    logic [AW:0] count;
    logic        wr, last_wr, sensor_en_d;
    logic [31:0] rdata, status;

    // Clear outranks a same-cycle sample.
    assign wr      = (state == SAMPLE) && sensor_ready && !sctrl_clear;
    assign last_wr = wr && (count == LAST);

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) state <= IDLE;
        else       state <= next_state;

    always_comb begin
        next_state = sctrl_clear                                   ? IDLE   :
                     (state == IDLE && sctrl_en && !sctrl_interrupt) ? SAMPLE :
                     last_wr                                       ? FULL   :
                     (state == SAMPLE && !sctrl_en)                ? IDLE   : state;
    end

    always_comb begin
        sensor_en_d = (state == SAMPLE);
        sctrl_out   = ~|sctrl_addr[11:AW] ? rdata : status;
    end

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            count           <= '0;
            sctrl_interrupt <= 1'b0;
            sensor_en       <= 1'b0;
        end else begin
            count           <= sctrl_clear ? '0 : wr ? count + ONE : count;
            sctrl_interrupt <= sctrl_clear ? 1'b0 : last_wr ? 1'b1 : sctrl_interrupt;
            sensor_en       <= sensor_en_d;
        end

`ifdef SENSOR_CTRL_OVERRUN_EN
    localparam logic [11:0] STATUS_ADDR = 12'(DEPTH + STATUS_OFFSET);

    logic overrun;

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) overrun <= 1'b0;
        else       overrun <= sctrl_clear ? 1'b0 : (state == FULL && sensor_ready) ? 1'b1 : overrun;

    assign status = (sctrl_addr == STATUS_ADDR) ? {15'b0, overrun, 16'(count)} : '0;
`else
    assign status = '0;
`endif

    sensor_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .CLK   (CLK),
        .we    (wr),
        .waddr (count[AW-1:0]),
        .wdata (sensor_out),
        .raddr (sctrl_addr[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sensor_ctrl.sv
// tb_sensor_ctrl: scoreboard bench for sensor_ctrl with a behavioural reference model.
module tb_sensor_ctrl;

    localparam int DEPTH = 64;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        sctrl_en = 1'b0;
    logic        sctrl_clear = 1'b0;
    logic [11:0] sctrl_addr = '0;
    logic [31:0] sctrl_out;
    logic        sctrl_interrupt;
    logic        sensor_en;
    logic        sensor_ready = 1'b0;
    logic [31:0] sensor_out = '0;

    always #5 CLK = ~CLK;

    sensor_ctrl #(.DEPTH(DEPTH)) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .sctrl_en        (sctrl_en),
        .sctrl_clear     (sctrl_clear),
        .sctrl_addr      (sctrl_addr),
        .sctrl_out       (sctrl_out),
        .sctrl_interrupt (sctrl_interrupt),
        .sensor_en       (sensor_en),
        .sensor_ready    (sensor_ready),
        .sensor_out      (sensor_out)
    );

    typedef enum {M_IDLE, M_SAMPLE, M_FULL} mmode_t;

    mmode_t      m_mode = M_IDLE;
    int          m_cnt = 0;
    bit          m_irq = 0, m_sen = 0, m_ovr = 0;
    logic [31:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];

    initial forever begin
        @(posedge CLK or negedge RSTn);
        if (!RSTn) begin
            m_mode = M_IDLE; m_cnt = 0; m_irq = 0; m_sen = 0; m_ovr = 0;
        end else begin
            m_sen = (m_mode == M_SAMPLE);
            if (sctrl_clear) begin
                m_mode = M_IDLE; m_cnt = 0; m_irq = 0; m_ovr = 0;
            end else if (m_mode == M_IDLE) begin
                if (sctrl_en) m_mode = M_SAMPLE;
            end else if (m_mode == M_SAMPLE) begin
                if (sensor_ready) begin
                    m_mem[m_cnt] = sensor_out;
                    m_wr[m_cnt]  = 1;
                    m_cnt++;
                end
                if (m_cnt == DEPTH) begin
                    m_mode = M_FULL; m_irq = 1;
                end else if (!sctrl_en) m_mode = M_IDLE;
            end else if (sensor_ready) m_ovr = 1;
        end
    end

    typedef struct {
        int          kind;
        logic [31:0] exp;
        logic [11:0] addr;
    } chk_t;

    chk_t sb[$];
    int   tests = 0, fails = 0;

    initial forever begin
        @(negedge CLK);
        while (sb.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            string       nm;
            c   = sb.pop_front();
            act = c.kind == 0 ? sctrl_out : c.kind == 1 ? 32'(sctrl_interrupt) : 32'(sensor_en);
            nm  = c.kind == 0 ? "sctrl_out" : c.kind == 1 ? "sctrl_interrupt" : "sensor_en";
            tests++;
            if (act !== c.exp) begin
                fails++;
                $display("FAIL %s addr=0x%0h t=%0t actual=0x%08h required=0x%08h", nm, c.addr, $time, act, c.exp);
            end
        end
    end

    function automatic logic [31:0] ref_read(input logic [11:0] a);
        if (a < DEPTH) return m_mem[a];
`ifdef SENSOR_CTRL_OVERRUN_EN
        if (a == DEPTH) return {15'b0, m_ovr, 16'(m_cnt)};
`endif
        return '0;
    endfunction

    function automatic logic [11:0] rand_addr();
        int i = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 3) == 0) return 12'($urandom_range(DEPTH, 4095));
        return m_wr[i] ? 12'(i) : 12'(DEPTH);
    endfunction

    task automatic push(input int k, input logic [31:0] e);
        chk_t c;
        c.kind = k; c.exp = e; c.addr = sctrl_addr;
        sb.push_back(c);
    endtask

    task automatic cycle();
        push(1, 32'(m_irq));
        push(2, 32'(m_sen));
        if (sctrl_addr >= DEPTH || m_wr[sctrl_addr[5:0]]) push(0, ref_read(sctrl_addr));
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_to(input int target, input logic [31:0] base);
        int n = 0;
        sctrl_clear = 0; sctrl_en = 1; sensor_ready = 1;
        while (m_cnt != target && n < 300) begin
            sensor_out = base + 32'(m_cnt);
            sctrl_addr = rand_addr();
            cycle();
            n++;
        end
        if (m_cnt != target) begin
            tests++; fails++;
            $display("FAIL fill_to count actual=%0d required=%0d", m_cnt, target);
        end
        sensor_ready = 0;
    endtask

    task automatic do_clear();
        sctrl_clear = 1; sensor_ready = 0; sctrl_en = 0;
        cycle();
        sctrl_clear = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        sctrl_addr = 12'(DEPTH);
        cycle();
        RSTn = 1;
        cycle();
        // full fill, interrupt on the 64th write
        fill_to(DEPTH, 32'h100);
        sctrl_en = 0;
        sctrl_addr = 5;      cycle();
        sctrl_addr = 63;     cycle();
        sctrl_addr = 12'h800; cycle();
        // samples in FULL are dropped, en has no effect
        for (int i = 0; i < 3; i++) begin
            sensor_ready = 1; sensor_out = $urandom; sctrl_en = i[0]; sctrl_addr = 12'(DEPTH);
            cycle();
            sensor_ready = 0;
            cycle();
        end
        sctrl_addr = 12'(DEPTH); cycle();
        sctrl_addr = 0;          cycle();
        sctrl_addr = 63;         cycle();
        // clear colliding with the last write
        do_clear();
        fill_to(DEPTH - 1, 32'h200);
        sctrl_clear = 1; sensor_ready = 1; sctrl_en = 1; sctrl_addr = 12'(DEPTH);
        cycle();
        repeat (3) cycle();
        sctrl_clear = 0; sensor_ready = 0;
        repeat (3) cycle();
        sctrl_en = 0; sctrl_addr = 63;
        repeat (2) cycle();
        // pause and resume
        do_clear();
        fill_to(10, 32'h300);
        sctrl_en = 0;
        cycle();
        for (int i = 0; i < 19; i++) begin
            sensor_ready = 1'($urandom_range(0, 1)); sctrl_addr = rand_addr();
            cycle();
        end
        fill_to(11, 32'hABC0_0000);
        sctrl_en = 0;
        sctrl_addr = 10; cycle();
        sctrl_addr = 9;  cycle();
        // asynchronous reset mid-fill
        do_clear();
        fill_to(30, 32'h400);
        RSTn = 0;
        #1;
        cycle();
        cycle();
        RSTn = 1;
        cycle();
        fill_to(1, 32'h5A5A_0000);
        sctrl_en = 0;
        sctrl_addr = 0; cycle();
        sctrl_addr = 1; cycle();
        // randomized traffic
        do_clear();
        repeat (600) begin
            sctrl_en     = $urandom_range(0, 3) != 0;
            sctrl_clear  = $urandom_range(0, 199) == 0;
            sensor_ready = 1'($urandom_range(0, 1));
            sensor_out   = $urandom;
            sctrl_addr   = rand_addr();
            cycle();
        end
        sctrl_en = 0; sctrl_clear = 0; sensor_ready = 0;
        cycle();
        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
